serial_to_parallel_stream: RTL and testbench

Parametrised serial-to-parallel deserializer with a multi-bit serial lane, selectable bit order, optional early word termination, and a ready/valid output with backpressure. It packs `width / lane_w` serial beats into one parallel word and holds that word in an output register until the downstream consumer accepts it. It sits between a serial receiver front-end and word-oriented datapath logic.

---
 rtl/serial_to_parallel_stream.sv | 109 ++++++++++
 tb/tb_serial_to_parallel_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_stream.sv
// Serial-to-parallel deserializer: packs width/lane_w beats into a word behind a ready/valid
// output register. Define SERIAL_TO_PARALLEL_PARTIAL_EN to let serial_last end a word early.
module serial_to_parallel_stream #(
  parameter int unsigned width  = 8,
  parameter int unsigned lane_w = 1,
  localparam int unsigned beats = width / lane_w,
  localparam int unsigned cnt_w = $clog2(beats + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msb_first,
  input  logic              serial_valid,
  output logic              serial_ready,
  input  logic [lane_w-1:0] serial_data,
  input  logic              serial_last,
  output logic              parallel_valid,
  input  logic              parallel_ready,
  output logic [width-1:0]  parallel_data,
  output logic [cnt_w-1:0]  parallel_beats
);

  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

`ifdef SERIAL_TO_PARALLEL_PARTIAL_EN
  localparam bit partial_en = 1'b1;
`else
  localparam bit partial_en = 1'b0;
`endif

  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [width-1:0] acc_q, acc_d;
  logic             order_q, order_d;
  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;
  logic [cnt_w-1:0] beats_q, beats_d;

  logic             completing;
  logic             accept;
  logic             consume;
  logic             order_cur;
  logic [cnt_w-1:0] slot;
  logic [31:0]      shamt;
  logic [width-1:0] beat_ext;
  logic [width-1:0] word_next;

  always_comb begin
    completing   = (cnt_q == last_cnt) || (partial_en && serial_last);
    serial_ready = !(valid_q && !parallel_ready && completing);
    accept       = serial_valid && serial_ready;
    consume      = valid_q && parallel_ready;
    // The order bit only takes effect from the first beat of a word.
    order_cur    = (cnt_q == '0) ? msb_first : order_q;
    slot         = order_cur ? (last_cnt - cnt_q) : cnt_q;
    shamt        = 32'(slot) * lane_w;
    beat_ext     = '0;
    beat_ext[lane_w-1:0] = serial_data;
    word_next    = acc_q | (beat_ext << shamt);
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    order_d = order_q;
    valid_d = valid_q;
    data_d  = data_q;
    beats_d = beats_q;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (cnt_q == '0) begin
        order_d = msb_first;
      end
      if (completing) begin
        data_d  = word_next;
        beats_d = cnt_q + cnt_w'(1);
        valid_d = 1'b1;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        acc_d = word_next;
        cnt_d = cnt_q + cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      order_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      beats_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      order_q <= order_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      beats_q <= beats_d;
    end
  end

  assign parallel_valid = valid_q;
  assign parallel_data  = data_q;
  assign parallel_beats = beats_q;

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Bench for serial_to_parallel_stream: 8/1 instance checked every cycle against a queue model,
// plus directed literal checks on 8/1 and 8/2 instances.
module tb_serial_to_parallel_stream;

`ifdef SERIAL_TO_PARALLEL_PARTIAL_EN
  localparam bit part = 1'b1;
`else
  localparam bit part = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_msb, s_valid, s_last, p_ready;
  logic [0:0] s_data;
  logic       s_ready, p_valid;
  logic [7:0] p_data;
  logic [3:0] p_beats;

  logic       s2_valid, s2_ready, s2_msb, s2_last, p2_ready, p2_valid;
  logic [1:0] s2_data;
  logic [7:0] p2_data;
  logic [2:0] p2_beats;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_to_parallel_stream #(.width(8), .lane_w(1)) dut (
    .clk(clk), .rst_n(rst_n), .msb_first(s_msb), .serial_valid(s_valid),
    .serial_ready(s_ready), .serial_data(s_data), .serial_last(s_last),
    .parallel_valid(p_valid), .parallel_ready(p_ready), .parallel_data(p_data),
    .parallel_beats(p_beats)
  );

  serial_to_parallel_stream #(.width(8), .lane_w(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .msb_first(s2_msb), .serial_valid(s2_valid),
    .serial_ready(s2_ready), .serial_data(s2_data), .serial_last(s2_last),
    .parallel_valid(p2_valid), .parallel_ready(p2_ready), .parallel_data(p2_data),
    .parallel_beats(p2_beats)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model of the 8/1 instance: collected beats of the current word plus the output register.
  bit         m_q[$];
  bit         m_order;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_beats;

  always @(negedge rst_n) begin
    m_q.delete();
    m_order = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_beats = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit done, rdy, take;
      logic [7:0] w;
      done = (m_q.size() == 7) || (part && s_last);
      rdy  = !(m_valid && !p_ready && done);
      take = s_valid && rdy;
      if (m_valid && p_ready) m_valid = 1'b0;
      if (take) begin
        if (m_q.size() == 0) m_order = s_msb;
        m_q.push_back(s_data[0]);
        if (done) begin
          w = '0;
          foreach (m_q[k]) w[m_order ? 7 - k : k] = m_q[k];
          m_data  = w;
          m_beats = m_q.size();
          m_valid = 1'b1;
          m_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_valid", 32'(p_valid), 32'(m_valid));
      if (m_valid) begin
        chk("cmp_data", 32'(p_data), 32'(m_data));
        chk("cmp_beats", 32'(p_beats), 32'(m_beats));
      end
      chk("cmp_ready", 32'(s_ready),
          32'(!(m_valid && !p_ready && ((m_q.size() == 7) || (part && s_last)))));
    end
  end

  task automatic send8(input logic [7:0] b, input logic msb, input int tog);
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = b[k];
      s_msb   = (tog >= 0 && k >= tog) ? ~msb : msb;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic partial_case(input logic msb, input logic [7:0] exp);
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 1'b1; s_msb = msb; s_last = (k == 2);
      @(posedge clk); #1;
    end
    s_last = 1'b0;
    if (part) begin
      s_valid = 1'b0;
      chk("part_valid", 32'(p_valid), 1);
      chk("part_data", 32'(p_data), 32'(exp));
      chk("part_beats", 32'(p_beats), 3);
    end else begin
      chk("nopart_none", 32'(p_valid), 0);
      for (int k = 3; k < 8; k++) begin
        s_data = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk("nopart_valid", 32'(p_valid), 1);
      chk("nopart_data", 32'(p_data), 32'(exp));
      chk("nopart_beats", 32'(p_beats), 8);
    end
    @(posedge clk); #1;
  endtask

  logic [1:0] l2 [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_msb = 0; s_valid = 0; s_last = 0; s_data = '0; p_ready = 1'b1;
    s2_msb = 0; s2_valid = 0; s2_last = 0; s2_data = '0; p2_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(p_valid), 0);
    chk("rst_data", 32'(p_data), 0);
    chk("rst_beats", 32'(p_beats), 0);
    chk("rst_ready", 32'(s_ready), 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    send8(8'h8D, 1'b0, -1);
    chk("lsb_valid", 32'(p_valid), 1);
    chk("lsb_data", 32'(p_data), 32'h8D);
    chk("lsb_beats", 32'(p_beats), 8);
    @(posedge clk); #1;
    chk("lsb_one_cycle", 32'(p_valid), 0);

    send8(8'h8D, 1'b1, -1);
    chk("msb_data", 32'(p_data), 32'hB1);
    send8(8'h8D, 1'b1, 3);
    chk("msb_toggle_data", 32'(p_data), 32'hB1);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      s2_valid = 1'b1; s2_data = l2[k];
      @(posedge clk); #1;
      if (k == 3) begin
        chk("l2_valid0", 32'(p2_valid), 1);
        chk("l2_data0", 32'(p2_data), 32'h39);
        chk("l2_beats0", 32'(p2_beats), 4);
      end
      if (k == 4) chk("l2_drop", 32'(p2_valid), 0);
    end
    s2_valid = 1'b0;
    chk("l2_valid1", 32'(p2_valid), 1);
    chk("l2_data1", 32'(p2_data), 32'hFF);

    p_ready = 1'b0;
    send8(8'h8D, 1'b0, -1);
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1; s_data = 8'hC3 >> k; s_msb = 1'b0;
      #1 chk("bp_accept", 32'(s_ready), 1);
      @(posedge clk); #1;
    end
    s_data = 1'b1;
    #1;
    chk("bp_stall", 32'(s_ready), 0);
    chk("bp_hold_data", 32'(p_data), 32'h8D);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_still_stall", 32'(s_ready), 0);
    chk("bp_still_data", 32'(p_data), 32'h8D);
    p_ready = 1'b1;
    #1 chk("bp_release", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("bp_new_valid", 32'(p_valid), 1);
    chk("bp_new_data", 32'(p_data), 32'hC3);
    @(posedge clk); #1;

    partial_case(1'b0, 8'h07);
    partial_case(1'b1, 8'hE0);

    p_ready = 1'b0;
    send8(8'hFF, 1'b0, -1);
    chk("mid_pending", 32'(p_valid), 1);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(p_valid), 0);
    chk("mid_rst_data", 32'(p_data), 0);
    chk("mid_rst_beats", 32'(p_beats), 0);
    chk("mid_rst_ready", 32'(s_ready), 1);
    #2 rst_n = 1'b1;
    p_ready = 1'b1;
    @(posedge clk); #1;
    send8(8'hAA, 1'b0, -1);
    chk("post_rst_valid", 32'(p_valid), 1);
    chk("post_rst_data", 32'(p_data), 32'hAA);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
